// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals/sync bounds and pixel types.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that returns to zero after MAX; wrap is high on the enabled cycle at MAX.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int WIDTH = COORD_W,
    parameter int MAX   = H_TOTAL - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a half-rate pixel tick; sync/blank/RGB are registered one pixel behind DrawX/DrawY.
// frame_start is a single-Clk pulse on the Clk after the last pixel of a frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int HTOT   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VTOT   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO  = H_VISIBLE + H_FP;
    localparam int HS_HI  = HS_LO + H_SYNC - 1;
    localparam int VS_LO  = V_VISIBLE + V_FP;
    localparam int VS_HI  = VS_LO + V_SYNC - 1;

    logic pix_en;
    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic visible;
    logic in_hsync;
    logic in_vsync;
    rgb_t rgb_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    assign tick = pix_en;

    wrap_counter #(.WIDTH(COORD_W), .MAX(HTOT - 1)) u_hc (
        .clk   (Clk),
        .rst   (Reset),
        .en    (tick),
        .count (DrawX),
        .wrap  (h_wrap)
    );

    wrap_counter #(.WIDTH(COORD_W), .MAX(VTOT - 1)) u_vc (
        .clk   (Clk),
        .rst   (Reset),
        .en    (tick & h_wrap),
        .count (DrawY),
        .wrap  (v_wrap)
    );

    // Decoded from the pre-increment counters so the registered outputs describe the pixel just drawn.
    assign visible  = (DrawX < coord_t'(H_VISIBLE)) && (DrawY < coord_t'(V_VISIBLE));
    assign in_hsync = (DrawX >= coord_t'(HS_LO)) && (DrawX <= coord_t'(HS_HI));
    assign in_vsync = (DrawY >= coord_t'(VS_LO)) && (DrawY <= coord_t'(VS_HI));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            rgb_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap;
            if (tick) begin
                VGA_HS      <= ~in_hsync;
                VGA_VS      <= ~in_vsync;
                VGA_BLANK_N <= visible;
                rgb_q       <= visible ? rgb_t'{r: Red_in, g: Green_in, b: Blue_in} : '0;
            end
        end
    end

    assign VGA_CLK    = pix_en;
    assign VGA_SYNC_N = 1'b0;
    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;

endmodule
